// File: rtl/float_pkg.sv
// -----------------------------------------------------------------------------
// float_pkg
// Shared definitions for the N_MAC float format: field widths, exponent bias,
// reserved exponent, and the 2-bit operand class encoding used by the
// float-to-fixed converter (and future fixed-to-float block).
// Field widths come from the `E_bit / `F_bit macros; float32 defaults are
// provided here when the including flow has not defined them.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef E_bit
`define E_bit 8
`endif
`ifndef F_bit
`define F_bit 23
`endif

package float_pkg;

  localparam int E_W  = `E_bit;      // exponent field width
  localparam int F_W  = `F_bit;      // fraction field width
  localparam int M_W  = F_W + 1;     // mantissa width including hidden one
  localparam int SH_W = E_W + 2;     // signed shift-amount width

  // Exponent bias and reserved Inf/NaN exponent, derived from the field width.
  localparam logic [E_W-1:0] E_REF = {1'b0, {(E_W-1){1'b1}}};
  localparam logic [E_W-1:0] E_MAX = {E_W{1'b1}};

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fclass_t;

  // Subnormals (e == 0) are flushed to zero.
  function automatic fclass_t classify(input logic [E_W-1:0] e,
                                       input logic [F_W-1:0] f);
    fclass_t c;
    if (e == {E_W{1'b0}}) begin
      c = CLS_ZERO;
    end else if (e == E_MAX) begin
      c = (f != {F_W{1'b0}}) ? CLS_NAN : CLS_INF;
    end else begin
      c = CLS_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/float_fix_align.sv
// -----------------------------------------------------------------------------
// float_fix_align
// Bidirectional barrel shifter placing a float mantissa onto a fixed-point
// grid. A non-negative shift moves left; a negative shift moves right and
// (when FIX_ROUND_NEAREST_EN is defined) exposes the most significant dropped
// bit as the guard bit. Right shifts beyond the mantissa width give zero.
// Purely combinational.
// Ports:
//   mant  in   M_W     mantissa {1, f}
//   sh    in   SH_W    signed shift amount (positive = left)
//   mag   out  O_W+1   aligned magnitude
//   guard out  1       first dropped bit (only with FIX_ROUND_NEAREST_EN)
// -----------------------------------------------------------------------------
module float_fix_align #(
  parameter int O_W  = 32,
  parameter int M_W  = 24,
  parameter int SH_W = 10
) (
  input  logic [M_W-1:0]         mant,
  input  logic signed [SH_W-1:0] sh,
  output logic [O_W:0]           mag
`ifdef FIX_ROUND_NEAREST_EN
  ,
  output logic                   guard
`endif
);

  localparam logic [SH_W-1:0] M_W_SH = SH_W'(M_W);

  logic [O_W:0]      ext_s;
  logic [SH_W-1:0]   nsh_s;
`ifdef FIX_ROUND_NEAREST_EN
  logic [M_W:0]      rsh_s;   // mantissa with one extra low bit to catch guard
`else
  logic [M_W-1:0]    rsh_s;
`endif

  // Select left or right alignment from the sign of the shift amount.
  always_comb begin
    ext_s = {{(O_W+1-M_W){1'b0}}, mant};
    nsh_s = $unsigned(-sh);
`ifdef FIX_ROUND_NEAREST_EN
    rsh_s = {mant, 1'b0} >> nsh_s;
    guard = 1'b0;
`else
    rsh_s = mant >> nsh_s;
`endif
    mag = {(O_W+1){1'b0}};
    if (!sh[SH_W-1]) begin
      mag = ext_s << $unsigned(sh);
    end else if (nsh_s > M_W_SH) begin
      mag = {(O_W+1){1'b0}};
    end else begin
`ifdef FIX_ROUND_NEAREST_EN
      mag   = {{(O_W+1-M_W){1'b0}}, rsh_s[M_W:1]};
      guard = rsh_s[0];
`else
      mag   = {{(O_W+1-M_W){1'b0}}, rsh_s};
`endif
    end
  end

endmodule

// File: rtl/float_to_fixed.sv
// -----------------------------------------------------------------------------
// float_to_fixed
// Three-stage pipelined converter from the N_MAC float format to signed
// two's-complement fixed point with Q fractional bits. Saturates on overflow
// and Inf, zeroes and flags NaN, flushes subnormals to zero.
// Stages: S0 decode/classify, S1 align (+ optional rounding), S2 sign/saturate.
// The whole pipeline advances together whenever the output register is empty
// or being drained, so throughput is one result per cycle with no bubbles.
// Build option: FIX_ROUND_NEAREST_EN selects round-half-away-from-zero;
// otherwise results are truncated toward zero.
// Ports:
//   clk       in   1            rising-edge clock
//   rst       in   1            asynchronous active-high reset
//   in_valid  in   1            in_data valid
//   in_ready  out  1            converter accepts in_data
//   in_data   in   E_W+F_W+1    float operand {s, e, f}
//   out_valid out  1            out_data valid
//   out_ready in   1            downstream accepts out_data
//   out_data  out  O_W          signed fixed result, Q fractional bits
//   out_ovf   out  1            result saturated (overflow or Inf)
//   out_inv   out  1            input was NaN (out_data is 0)
// -----------------------------------------------------------------------------
module float_to_fixed
  import float_pkg::*;
#(
  parameter int O_W = 32,
  parameter int Q   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [E_W+F_W:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [O_W-1:0]   out_data,
  output logic             out_ovf,
  output logic             out_inv
);

  localparam logic signed [SH_W-1:0] SH_OFF  = SH_W'(Q - F_W);
  localparam logic signed [SH_W-1:0] EOVF_TH = SH_W'(O_W - 1 - Q);
  localparam logic [O_W:0]   LIM_POS = {2'b00, {(O_W-1){1'b1}}};
  localparam logic [O_W:0]   LIM_NEG = {2'b01, {(O_W-1){1'b0}}};
  localparam logic [O_W-1:0] SAT_POS = {1'b0, {(O_W-1){1'b1}}};
  localparam logic [O_W-1:0] SAT_NEG = {1'b1, {(O_W-1){1'b0}}};

  logic adv_s;

  // S0 decode signals
  logic                   in_sign_s;
  logic [E_W-1:0]         in_exp_s;
  logic [F_W-1:0]         in_frac_s;
  logic signed [SH_W-1:0] exp_unb_s;
  logic signed [SH_W-1:0] sh_s;
  logic                   eovf_s;
  logic                   bnd_s;
  fclass_t                cls_s;

  // S0 registers
  logic                   s0_valid_r;
  logic                   s0_sign_r;
  logic [M_W-1:0]         s0_mant_r;
  logic signed [SH_W-1:0] s0_sh_r;
  fclass_t                s0_cls_r;
  logic                   s0_eovf_r;
  logic                   s0_bnd_r;

  // S1 alignment
  logic [O_W:0]           mag_s;
  logic [O_W:0]           mag_rnd_s;
`ifdef FIX_ROUND_NEAREST_EN
  logic                   guard_s;
`endif

  // S1 registers
  logic                   s1_valid_r;
  logic                   s1_sign_r;
  fclass_t                s1_cls_r;
  logic                   s1_eovf_r;
  logic                   s1_bnd_r;
  logic [O_W:0]           s1_mag_r;

  // S2 next-output signals
  logic [O_W:0]           lim_s;
  logic                   exc_s;
  logic [O_W-1:0]         nxt_data_s;
  logic                   nxt_ovf_s;
  logic                   nxt_inv_s;

  // Output registers
  logic                   out_valid_r;
  logic [O_W-1:0]         out_data_r;
  logic                   out_ovf_r;
  logic                   out_inv_r;

  assign adv_s     = !out_valid_r || out_ready;
  assign in_ready  = adv_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ovf   = out_ovf_r;
  assign out_inv   = out_inv_r;

  // S0 combinational decode: fields, shift amount, class, overflow hints.
  always_comb begin
    in_sign_s = in_data[E_W+F_W];
    in_exp_s  = in_data[E_W+F_W-1:F_W];
    in_frac_s = in_data[F_W-1:0];
    exp_unb_s = $signed({2'b00, in_exp_s}) - $signed({2'b00, E_REF});
    sh_s      = exp_unb_s + SH_OFF;
    eovf_s    = (exp_unb_s >= EOVF_TH);
    // At exactly the threshold the aligned magnitude still fits, which is
    // what lets -2^(O_W-1-Q) map to the minimum value without saturating.
    bnd_s     = (exp_unb_s == EOVF_TH);
    cls_s     = classify(in_exp_s, in_frac_s);
  end

  // S0 pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_r <= 1'b0;
      s0_sign_r  <= 1'b0;
      s0_mant_r  <= {M_W{1'b0}};
      s0_sh_r    <= {SH_W{1'b0}};
      s0_cls_r   <= CLS_ZERO;
      s0_eovf_r  <= 1'b0;
      s0_bnd_r   <= 1'b0;
    end else if (adv_s) begin
      s0_valid_r <= in_valid;
      s0_sign_r  <= in_sign_s;
      s0_mant_r  <= {1'b1, in_frac_s};
      s0_sh_r    <= sh_s;
      s0_cls_r   <= cls_s;
      s0_eovf_r  <= eovf_s;
      s0_bnd_r   <= bnd_s;
    end
  end

  float_fix_align #(
    .O_W  (O_W),
    .M_W  (M_W),
    .SH_W (SH_W)
  ) u_align (
    .mant  (s0_mant_r),
    .sh    (s0_sh_r),
    .mag   (mag_s)
`ifdef FIX_ROUND_NEAREST_EN
    ,
    .guard (guard_s)
`endif
  );

  // S1 rounding: add the guard bit (half away from zero) or pass through.
  always_comb begin
`ifdef FIX_ROUND_NEAREST_EN
    mag_rnd_s = mag_s + {{O_W{1'b0}}, guard_s};
`else
    mag_rnd_s = mag_s;
`endif
  end

  // S1 pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_cls_r   <= CLS_ZERO;
      s1_eovf_r  <= 1'b0;
      s1_bnd_r   <= 1'b0;
      s1_mag_r   <= {(O_W+1){1'b0}};
    end else if (adv_s) begin
      s1_valid_r <= s0_valid_r;
      s1_sign_r  <= s0_sign_r;
      s1_cls_r   <= s0_cls_r;
      s1_eovf_r  <= s0_eovf_r;
      s1_bnd_r   <= s0_bnd_r;
      s1_mag_r   <= mag_rnd_s;
    end
  end

  // S2 sign application and saturation.
  always_comb begin
    lim_s      = s1_sign_r ? LIM_NEG : LIM_POS;
    exc_s      = s1_sign_r && s1_bnd_r && (s1_mag_r == LIM_NEG);
    nxt_data_s = {O_W{1'b0}};
    nxt_ovf_s  = 1'b0;
    nxt_inv_s  = 1'b0;
    case (s1_cls_r)
      CLS_NAN: begin
        nxt_inv_s = 1'b1;
      end
      CLS_INF: begin
        nxt_data_s = s1_sign_r ? SAT_NEG : SAT_POS;
        nxt_ovf_s  = 1'b1;
      end
      CLS_ZERO: begin
        nxt_data_s = {O_W{1'b0}};
      end
      CLS_NORM: begin
        if ((s1_eovf_r && !exc_s) || (s1_mag_r > lim_s)) begin
          nxt_data_s = s1_sign_r ? SAT_NEG : SAT_POS;
          nxt_ovf_s  = 1'b1;
        end else if (s1_sign_r) begin
          // A zero magnitude negates to zero, so no negative zero appears.
          nxt_data_s = {O_W{1'b0}} - s1_mag_r[O_W-1:0];
        end else begin
          nxt_data_s = s1_mag_r[O_W-1:0];
        end
      end
      default: begin
        nxt_data_s = {O_W{1'b0}};
      end
    endcase
  end

  // Output register; holds its contents while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {O_W{1'b0}};
      out_ovf_r   <= 1'b0;
      out_inv_r   <= 1'b0;
    end else if (adv_s) begin
      out_valid_r <= s1_valid_r;
      out_data_r  <= nxt_data_s;
      out_ovf_r   <= nxt_ovf_s;
      out_inv_r   <= nxt_inv_s;
    end
  end

endmodule

// File: tb/tb_float_to_fixed.sv
// -----------------------------------------------------------------------------
// tb_float_to_fixed
// Scoreboard bench for float_to_fixed (float32, O_W=32, Q=16). Directed cases
// carry hand-derived constants; random cases use a reference model that
// evaluates the float value with integer arithmetic (multiply/divide by
// powers of two) and clamps it to the 32-bit signed range.
// -----------------------------------------------------------------------------
module tb_float_to_fixed;

  localparam int O_W = 32;
  localparam int Q   = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

`ifdef FIX_ROUND_NEAREST_EN
  localparam logic [31:0] R_POS = 32'h00000001;
  localparam logic [31:0] R_NEG = 32'hFFFFFFFF;
`else
  localparam logic [31:0] R_POS = 32'h00000000;
  localparam logic [31:0] R_NEG = 32'h00000000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_inv;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        inv;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_sent = 0;
  int   n_out = 0;
  bit   strict_lat = 1'b0;
  bit   rnd_done = 1'b0;

  float_to_fixed #(.O_W(O_W), .Q(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_inv   (out_inv)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: value = m * 2^(e-127-23), scaled by 2^Q, then clamped.
  function automatic void ref_model(input logic [31:0] x, output logic [31:0] d,
                                    output logic o, output logic i);
    int     e;
    int     k;
    longint m;
    longint mag;
    longint dv;
    longint v;
`ifdef FIX_ROUND_NEAREST_EN
    longint r;
`endif
    e = int'(x[30:23]);
    d = 32'h0;
    o = 1'b0;
    i = 1'b0;
    if (e == 255) begin
      if (x[22:0] != 23'h0) begin
        i = 1'b1;
      end else begin
        o = 1'b1;
        d = x[31] ? 32'h80000000 : 32'h7FFFFFFF;
      end
      return;
    end
    if (e == 0) return;
    m = longint'({1'b1, x[22:0]});
    k = e - 127 - 23 + Q;
    if (k >= 0) begin
      mag = (k > 30) ? (64'sd1 <<< 40) : m * (64'sd1 <<< k);
    end else if (-k > 40) begin
      mag = 64'sd0;
    end else begin
      dv  = 64'sd1 <<< (-k);
      mag = m / dv;
`ifdef FIX_ROUND_NEAREST_EN
      r = m % dv;
      if (2 * r >= dv) mag = mag + 64'sd1;
`endif
    end
    v = x[31] ? -mag : mag;
    if (v > MAXV) begin
      d = 32'h7FFFFFFF;
      o = 1'b1;
    end else if (v < MINV) begin
      d = 32'h80000000;
      o = 1'b1;
    end else begin
      d = v[31:0];
    end
  endfunction

  // Present one operand, wait (bounded) for acceptance, record the expectation.
  task automatic send(input logic [31:0] x, input logic [31:0] d, input logic o, input logic i);
    bit done = 1'b0;
    int acc = 0;
    in_valid = 1'b1;
    in_data  = x;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc  = cyc;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (done) begin
      sb_q.push_back('{d, o, i, acc});
      n_sent++;
    end else begin
      check("accept_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic send_model(input logic [31:0] x);
    logic [31:0] d;
    logic o;
    logic i;
    ref_model(x, d, o, i);
    send(x, d, o, i);
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: protocol check every cycle, scoreboard compare on each transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", {32'd0, out_data}, 64'hDEAD);
        end else begin
          e = sb_q[0];
          if (out_ready) begin
            void'(sb_q.pop_front());
            n_out++;
            check("out_data", {32'd0, out_data}, {32'd0, e.data});
            check("out_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
            check("out_inv", {63'd0, out_inv}, {63'd0, e.inv});
            if (strict_lat) check("latency", 64'(cyc - e.acc), 64'd3);
          end else begin
            check("stall_hold", {32'd0, out_data}, {32'd0, e.data});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
    check("rst_out_inv", {63'd0, out_inv}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;

    // Directed values with hand-derived results.
    strict_lat = 1'b1;
    send(32'h3F800000, 32'h00010000, 1'b0, 1'b0);
    send(32'hC0200000, 32'hFFFD8000, 1'b0, 1'b0);
    send(32'h471C4000, 32'h7FFFFFFF, 1'b1, 1'b0);
    send(32'hC7000000, 32'h80000000, 1'b0, 1'b0);
    send(32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0);
    send(32'hFF800000, 32'h80000000, 1'b1, 1'b0);
    send(32'h7FC00000, 32'h00000000, 1'b0, 1'b1);
    send(32'h00400000, 32'h00000000, 1'b0, 1'b0);
    send(32'h80000000, 32'h00000000, 1'b0, 1'b0);
    send(32'h37400000, R_POS, 1'b0, 1'b0);
    send(32'hB7400000, R_NEG, 1'b0, 1'b0);
    send(32'h46FFFFFE, 32'h7FFFFF00, 1'b0, 1'b0);
    drain();

    // Backpressure: six back-to-back values, output stalled for five cycles.
    strict_lat = 1'b0;
    fork
      begin
        for (int n = 0; n < 6; n++) send_model(32'h3F800000 + (n * 32'h00080000));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three values in flight: all are discarded.
    strict_lat = 1'b1;
    send_model(32'h40000000);
    send_model(32'h40400000);
    send_model(32'h40800000);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    n_sent = n_sent - sb_q.size();
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_idle", {63'd0, out_valid}, 64'd0);
    send(32'hBF800000, 32'hFFFF0000, 1'b0, 1'b0);
    drain();

    // Random operands with random backpressure.
    strict_lat = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          x = $urandom;
          if ($urandom_range(0, 3) != 0) x[30:23] = 8'($urandom_range(100, 160));
          send_model(x);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    check("result_count", 64'(n_out), 64'(n_sent));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
